// File: rtl/clock_divider.sv
// Divide-by-4 clock generator.
// A free-running 2-bit phase counter steps once per input edge. clk_out
// toggles whenever the pre-edge counter is odd, so it tracks counter[1]
// and gives a 50% duty output at a quarter of the clk frequency. Both
// outputs come straight from flops. There is no combinational path from
// rst or counter to either output.
module clock_divider (
  input  logic       clk,
  input  logic       rst,
  output logic       clk_out,
  output logic [1:0] counter
);

  logic [1:0] counter_q, counter_d;
  logic       clk_out_q, clk_out_d;

  // Next-state: the counter wraps 3->0 naturally in two bits.
  // The divided clock flips on odd phases (1 and 3).
  always_comb begin
    counter_d = counter_q + 2'd1;
    clk_out_d = counter_q[0] ? ~clk_out_q : clk_out_q;
  end

  // State registers: synchronous reset takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= 2'b00;
      clk_out_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign counter = counter_q;
  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: a directed vector table, free-run,
// period and wrap checks, then random resets against an edge-count model.
module tb_clock_divider;

  logic       clk;
  logic       rst;
  logic       clk_out;
  logic [1:0] counter;

  int vectors;
  int miscompares;
  int ref_n;

  clock_divider dut (
    .clk     (clk),
    .rst     (rst),
    .clk_out (clk_out),
    .counter (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst;
    logic [1:0] exp_cnt;
    logic       exp_clk;
  } vec_t;

  // Compare one observed value with its expectation.
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply rst for one rising edge and sample 1 ns after it.
  // The model counts edges since the last reset edge.
  task automatic step(input logic r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    if (r) ref_n = 0;
    else   ref_n = ref_n + 1;
  endtask

  // Check both outputs against the model.
  // The model gives counter = n mod 4 and clk_out high for phases 2 and 3.
  task automatic chk_model(input string nm);
    logic [1:0] ph;
    ph = 2'(ref_n % 4);
    chk({nm, "_cnt"}, 32'(counter), 32'(ph));
    chk({nm, "_clk"}, 32'(clk_out), 32'((ref_n % 4) >= 2));
  endtask

  vec_t tbl[$];

  initial begin
    logic [1:0] prev_cnt;
    logic       prev_clk;
    int         run_len;
    bit         seen_change;
    time        last_rise;
    bit         have_rise;

    vectors     = 0;
    miscompares = 0;
    ref_n       = 0;
    rst         = 1'b1;

    // Directed table: reset, free-run, mid-run reset at (2,1), extended reset, resume.
    tbl.push_back('{1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b1});
    tbl.push_back('{1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 2'd0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst);
      chk($sformatf("tbl%0d_cnt", i), 32'(counter), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_clk", i), 32'(clk_out), 32'(tbl[i].exp_clk));
    end

    // Free run of 27 edges from a fresh reset.
    // Checks phase, clk_out==counter[1], half-periods, 40 ns period and the 3->0 wrap.
    step(1'b1);
    chk_model("fr_reset");
    prev_cnt    = counter;
    prev_clk    = clk_out;
    run_len     = 1;
    seen_change = 1'b0;
    have_rise   = 1'b0;
    last_rise   = 0;
    for (int e = 1; e <= 27; e++) begin
      step(1'b0);
      chk_model($sformatf("fr%0d", e));
      chk("fr_inv", 32'(clk_out), 32'(counter[1]));
      if (prev_cnt == 2'd3) begin
        chk("wrap_cnt", 32'(counter), 32'd0);
        chk("wrap_fall", 32'({prev_clk, clk_out}), 32'(2'b10));
      end
      if (clk_out !== prev_clk) begin
        if (seen_change) chk("half_period", 32'(run_len), 32'd2);
        seen_change = 1'b1;
        run_len     = 1;
        if (clk_out === 1'b1) begin
          if (have_rise) chk("clk_out_period_ns", 32'($time - last_rise), 32'd40);
          last_rise = $time;
          have_rise = 1'b1;
        end
      end else begin
        run_len++;
      end
      prev_cnt = counter;
      prev_clk = clk_out;
    end

    // Random reset pattern against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 8) == 0);
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Synchronous divide-by-4 clock generator built around a free-running 2-bit counter.
- Produces a registered 50%-duty output clock, clk_out, at one quarter of the input clock frequency.
- Exposes the internal counter for debug and phase reference.
- Sits in the clocking/utility area; downstream logic uses clk_out as a slow clock or enable reference.

Parameters:
- None. Counter width is fixed at 2 bits and the divide ratio is fixed at 4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- clk_out  output  1  divided clock, period = 4 clk cycles, 50% duty, registered
- counter  output  2  free-running phase counter, registered

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high. rst is sampled only on the rising edge of clk.
- Reset: on any rising edge with rst=1:
  - counter <= 2'b00
  - clk_out <= 0
  - Reset takes priority over counting.
- Counting: on each rising edge with rst=0:
  - counter <= counter + 1, modulo 4.
  - 2'b11 wraps to 2'b00 with no stall or extra cycle.
- clk_out update: on each rising edge with rst=0:
  - clk_out <= ~clk_out when the pre-edge counter is 2'b01 or 2'b11 (counter[0]==1).
  - Otherwise clk_out holds.
- Invariant: after the first reset edge, clk_out == counter[1] at every edge.
  - clk_out is 0 for counter 0 and 1.
  - clk_out is 1 for counter 2 and 3.
- Sequence from reset release, pairs of (counter, clk_out) after each edge: (1,0) (2,1) (3,1) (0,0) (1,0) ... repeating every 4 edges.
- Timing:
  - clk_out is registered, with no combinational path from rst or counter to clk_out.
  - The first clk_out rising edge occurs on the 2nd clk rising edge after rst deasserts.
- Reset mid-operation: asserting rst at any phase forces (0,0) on the next edge. Counting resumes from 0 on the first edge with rst=0.
- Before the first reset edge: outputs are undefined (X). No power-on initial value is required.
- Multiple consecutive reset cycles: outputs hold at (0,0) for the whole reset period.

Test Plan:
- Reset: clk period 10 ns, rst=1 for one rising edge, then 0 -> counter=00, clk_out=0 immediately after the reset edge.
- Free-run: 27 edges after reset release -> counter sequence 01,10,11,00,... wraps cleanly. Check counter==(edge_count mod 4) at every edge.
- Divided clock: same run -> clk_out toggles every 2 clk edges, high for exactly 2 cycles and low for exactly 2 cycles. clk_out period = 40 ns. clk_out==counter[1] every cycle.
- Mid-run reset: assert rst for one edge while counter=10 and clk_out=1 -> next edge gives counter=00, clk_out=0. The edge after release gives counter=01, clk_out=0.
- Extended reset: hold rst=1 for 5 edges -> counter stays 00 and clk_out stays 0 throughout. Normal sequence resumes on release.
- Wrap boundary: observe the edge where counter goes 11->00 -> clk_out falls 1->0 on the same edge, with no glitch and no skipped count.
